// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : fetch_stage
// Description : Instruction-fetch stage of the 5-stage 16-bit pipeline. Owns
//               the PC, drives the instruction-memory address and loads the
//               IF/ID pipeline register. Fetch stops on HLT until reset.
// Ports       : clk, rst            - clock, synchronous active-high reset
//               stall               - hold PC and IF/ID
//               redirect_valid/_pc  - taken-branch redirect from decode
//               imem_addr/_rd_en    - instruction memory address / read enable
//               imem_data           - asynchronous-read instruction word
//               ifid_instr/_pc_plus2/_valid - IF/ID pipeline register
//               fetch_halted        - sticky, set once HLT enters IF/ID
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_stage #(
  parameter logic [15:0] RESET_PC   = 16'h0000,
  parameter logic [3:0]  HLT_OPCODE = 4'hF,
  parameter logic [15:0] NOP_INSTR  = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [15:0] redirect_pc,
  output logic [15:0] imem_addr,
  output logic        imem_rd_en,
  input  logic [15:0] imem_data,
  output logic [15:0] ifid_instr,
  output logic [15:0] ifid_pc_plus2,
  output logic        ifid_valid,
  output logic        fetch_halted
);

  typedef enum logic [0:0] {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } state_t;

  localparam logic [15:0] c_pc_step = 16'd2;

  state_t      r_state;
  logic [15:0] r_pc;
  logic [15:0] r_ifid_instr;
  logic [15:0] r_ifid_pc_plus2;
  logic        r_ifid_valid;

  logic [15:0] w_pc_plus2;
  logic        w_is_hlt;

  // 16-bit modulo increment: FFFE wraps to 0000 silently.
  assign w_pc_plus2 = r_pc + c_pc_step;
  assign w_is_hlt   = (imem_data[15:12] == HLT_OPCODE);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state         <= ST_RUN;
      r_pc            <= RESET_PC;
      r_ifid_instr    <= NOP_INSTR;
      r_ifid_pc_plus2 <= 16'h0000;
      r_ifid_valid    <= 1'b0;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (redirect_valid) begin
            // Branch wins over stall: the word fetched from the wrong path
            // (even an HLT) is squashed into a bubble.
            r_pc            <= {redirect_pc[15:1], 1'b0};
            r_ifid_instr    <= NOP_INSTR;
            r_ifid_pc_plus2 <= 16'h0000;
            r_ifid_valid    <= 1'b0;
          end else if (!stall) begin
            r_ifid_instr    <= imem_data;
            r_ifid_pc_plus2 <= w_pc_plus2;
            r_ifid_valid    <= 1'b1;
            if (w_is_hlt) begin
              // PC parks on the HLT address.
              r_state <= ST_HALTED;
            end else begin
              r_pc <= w_pc_plus2;
            end
          end
        end
        ST_HALTED: begin
          // While decode is stalled the HLT stays in IF/ID so it is not lost.
          if (!stall) begin
            r_ifid_instr    <= NOP_INSTR;
            r_ifid_pc_plus2 <= 16'h0000;
            r_ifid_valid    <= 1'b0;
          end
        end
        default: r_state <= ST_RUN;
      endcase
    end
  end

  assign imem_addr     = r_pc;
  assign imem_rd_en    = (r_state == ST_RUN);
  assign fetch_halted  = (r_state == ST_HALTED);
  assign ifid_instr    = r_ifid_instr;
  assign ifid_pc_plus2 = r_ifid_pc_plus2;
  assign ifid_valid    = r_ifid_valid;

endmodule
`default_nettype wire
